serial_rx_ctrl: RTL
===================

// Module: serial_rx_ctrl
// PURPOSE
//  Receive sequencer for the serial link. Synchronises the rx line and detects the start bit.
//  Enables the external bit-sampling counter and consumes its one-per-bit mid-bit sample pulse.
//  Frames start + DATA_BITS (LSB first) + 1 stop bit, presents the received byte through a
//  valid/ack handshake, and flags framing, timeout and overrun errors.
// PARAMETERS
//  DATA_BITS   8    data bits per frame, LSB first on the line
//  TIMEOUT     32   max clk cycles between sample_tick pulses while busy (2 x 16x oversample)
// PORTS
//  clk          in   1          system clock; all logic on posedge
//  reset        in   1          synchronous, active-high
//  rx_in        in   1          asynchronous serial line, idle high
//  sample_tick  in   1          1-clk pulse from bit-sampling counter, once per bit, mid-bit
//  bit_en       out  1          enable to bit-sampling counter; low resets its phase
//  rx_data      out  DATA_BITS  last accepted character, stable while rx_valid=1
//  rx_valid     out  1          character available; held until rx_ack
//  rx_ack       in   1          consumer accepts rx_data; clears rx_valid/overrun next edge
//  frame_err    out  1          1-clk pulse: stop bit low or sample_tick timeout
//  overrun      out  1          sticky: frame completed while rx_valid still set
//  busy         out  1          state != IDLE
// BEHAVIOUR
//  Reset values: bit_en=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE.
//  Reset values (cont.): sync flops=1, bit_cnt=0, wd_cnt=0. Reset mid-frame aborts without any flag.
//  rx_s is rx_in after a 2-flop synchroniser; start detect latency is 2 clk.
//  All outputs are registered.
//  FSM:
//   IDLE  : bit_en=0. rx_s==0 -> START, bit_en=1, wd_cnt=0.
//   START : on sample_tick: rx_s==0 -> DATA, bit_cnt=0.
//           rx_s==1 -> false start -> IDLE, no flags.
//   DATA  : on sample_tick: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, bit_cnt++.
//           After tick number DATA_BITS -> STOP.
//   STOP  : on sample_tick: rx_s==1 -> deliver shreg -> IDLE.
//           rx_s==0 -> frame_err pulse -> BREAK.
//   BREAK : bit_en=0; wait rx_s==1 -> IDLE. A held-low line never re-triggers a start.
//  Watchdog: in START/DATA/STOP, wd_cnt increments each clk and clears on sample_tick.
//   When wd_cnt==TIMEOUT-1 with no tick: frame_err pulse, shreg discarded, -> IDLE.
//  bit_en is low for at least 1 clk between frames: IDLE always entered before next START.
//  Deliver, rx_valid==0: rx_data<=shreg, rx_valid<=1 on the edge after the stop tick.
//  Deliver, rx_valid==1 && !rx_ack: rx_data keeps the old char, overrun<=1, new char dropped.
//  Deliver, rx_valid==1 && rx_ack same cycle: load new char, rx_valid stays 1, no overrun.
//  rx_ack with no delivery: rx_valid<=0, overrun<=0. rx_ack while rx_valid==0: no effect.
//  sample_tick in IDLE/BREAK is ignored. bit_cnt width $clog2(DATA_BITS+1); wd_cnt $clog2(TIMEOUT).
// STRUCTURE
//  Shared package/include serial_defs.vh:
//   FSM state encodings (IDLE, START, DATA, STOP, BREAK; 3 bits), default DATA_BITS, OVERSAMPLE=16.
//  Sub-module: sync2 (2-flop synchroniser, reset value parameterised, here 1).
//  Remainder lives inline: FSM, bit_cnt, wd_cnt, shreg, output registers.
// TESTING  (bench instantiates the bit-sampling counter: bit_en -> enable, its output -> sample_tick)
//  1 Frame 0xA5 at 16 clk/bit, rx_ack low -> rx_valid=1, rx_data=8'hA5, frame_err never high.
//  1 (cont.) Ack -> rx_valid=0 next edge.
//  2 Glitch: rx_in low 4 clk then high -> no rx_valid, no frame_err.
//  2 (cont.) bit_en drops after the first tick; busy=0 within 12 clk.
//  3 Frame 0x55 with stop bit 0, line held low 40 clk -> frame_err exactly 1 clk, rx_valid=0.
//  3 (cont.) State BREAK until line high; next frame 0x81 received.
//  4 Frames 0x3C then 0xC3, no ack -> rx_data=8'h3C, overrun=1; one rx_ack clears both.
//  4 (cont.) Ack on the delivery edge of 0xC3 -> rx_data=8'hC3, overrun=0.
//  5 sample_tick forced 0 after start edge -> frame_err pulse 32 clk after START entry, then IDLE.
//  6 reset pulsed mid-DATA (after bit 3) -> next edge bit_en=0, busy=0, rx_valid=0.
//  6 (cont.) The following frame 0x0F is received correctly.

Source files
------------

// File: rtl/serial_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_rx_ctrl_pkg
// Summary : Shared constants and FSM state encodings for the serial receiver
// Rev     : 1.0
// ============================================================================
package serial_rx_ctrl_pkg;

    localparam int c_DATA_BITS_DEFAULT = 8;
    localparam int c_OVERSAMPLE        = 16;
    localparam int c_TIMEOUT_DEFAULT   = 2 * c_OVERSAMPLE;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] rx_state_t;

    localparam rx_state_t c_ST_IDLE  = 3'd0;
    localparam rx_state_t c_ST_START = 3'd1;
    localparam rx_state_t c_ST_DATA  = 3'd2;
    localparam rx_state_t c_ST_STOP  = 3'd3;
    localparam rx_state_t c_ST_BREAK = 3'd4;

    // States in which the bit-sampling counter runs and the watchdog is armed
    function automatic logic is_framing(input rx_state_t s);
        return (s == c_ST_START) || (s == c_ST_DATA) || (s == c_ST_STOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_rx_ctrl_if
// Summary : Received-character handshake and error flags toward the consumer
// Rev     : 1.0
// ============================================================================
interface serial_rx_ctrl_if #(
    parameter int DATA_BITS = serial_rx_ctrl_pkg::c_DATA_BITS_DEFAULT
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ack
    );

endinterface
`default_nettype wire

// File: rtl/serial_rx_ctrl_sync2.sv
`default_nettype none
// ============================================================================
// Module  : serial_rx_ctrl_sync2
// Summary : Two-flop synchroniser with selectable reset value
// Rev     : 1.0
// ============================================================================
module serial_rx_ctrl_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/serial_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_rx_ctrl
// Summary : Start detect, bit framing, valid/ack delivery and error flagging
// Rev     : 1.0
// ============================================================================
module serial_rx_ctrl
    import serial_rx_ctrl_pkg::*;
#(
    parameter int DATA_BITS = c_DATA_BITS_DEFAULT,
    parameter int TIMEOUT   = c_TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_in,
    input  logic             sample_tick,
    output logic             bit_en,
    output logic             busy,
    serial_rx_ctrl_if.master rx_bus
);

    localparam int c_BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam int c_WD_CNT_W  = $clog2(TIMEOUT);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [c_WD_CNT_W-1:0]  c_WD_LAST  = c_WD_CNT_W'(TIMEOUT - 1);

    logic                   w_rx_s;
    rx_state_t              r_state;
    rx_state_t              w_next_state;
    logic [c_BIT_CNT_W-1:0] r_bit_cnt;
    logic [c_WD_CNT_W-1:0]  r_wd_cnt;
    logic [DATA_BITS-1:0]   r_shreg;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_overrun;
    logic                   r_frame_err;
    logic                   r_bit_en;
    logic                   r_busy;

    logic w_framing;
    logic w_timeout;
    logic w_last_bit;
    logic w_deliver;
    logic w_shift;
    logic w_bit_en_nxt;
    logic w_busy_nxt;
    logic w_frame_err_nxt;

    serial_rx_ctrl_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    assign w_framing  = is_framing(r_state);
    assign w_timeout  = w_framing && !sample_tick && (r_wd_cnt == c_WD_LAST);
    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_rx_s) w_next_state = c_ST_START;
            end
            c_ST_START: begin
                if (w_timeout)        w_next_state = c_ST_IDLE;
                else if (sample_tick) w_next_state = w_rx_s ? c_ST_IDLE : c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_timeout)                      w_next_state = c_ST_IDLE;
                else if (sample_tick && w_last_bit) w_next_state = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_timeout)        w_next_state = c_ST_IDLE;
                else if (sample_tick) w_next_state = w_rx_s ? c_ST_IDLE : c_ST_BREAK;
            end
            // A line stuck low parks here so it cannot look like a new start bit
            c_ST_BREAK: begin
                if (w_rx_s) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_bit_en_nxt    = is_framing(w_next_state);
        w_busy_nxt      = (w_next_state != c_ST_IDLE);
        w_shift         = (r_state == c_ST_DATA) && sample_tick;
        w_deliver       = (r_state == c_ST_STOP) && sample_tick && w_rx_s;
        w_frame_err_nxt = w_timeout || ((r_state == c_ST_STOP) && sample_tick && !w_rx_s);
    end

    // Watchdog only counts while framing; IDLE holds it at zero so START begins fresh
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_wd_cnt  <= '0;
            r_shreg   <= '0;
        end else begin
            if (!w_framing || sample_tick) r_wd_cnt <= '0;
            else                           r_wd_cnt <= r_wd_cnt + 1'b1;

            if ((r_state == c_ST_START) && sample_tick) r_bit_cnt <= '0;
            else if (w_shift)                           r_bit_cnt <= r_bit_cnt + 1'b1;

            if (w_shift) r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_bit_en    <= w_bit_en_nxt;
            r_busy      <= w_busy_nxt;
            r_frame_err <= w_frame_err_nxt;
            // An ack coinciding with delivery frees the slot for the new character
            if (w_deliver && (!r_rx_valid || rx_bus.rx_ack)) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
                r_overrun  <= 1'b0;
            end else if (w_deliver) begin
                r_overrun  <= 1'b1;
            end else if (rx_bus.rx_ack && r_rx_valid) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
        end
    end

    assign bit_en           = r_bit_en;
    assign busy             = r_busy;
    assign rx_bus.rx_data   = r_rx_data;
    assign rx_bus.rx_valid  = r_rx_valid;
    assign rx_bus.frame_err = r_frame_err;
    assign rx_bus.overrun   = r_overrun;

endmodule
`default_nettype wire
